// File: rtl/sha256_pkg.sv
// Shared types, widths and message padding for the SHA-256 nonce search stage.
package sha256_pkg;

    localparam int unsigned SHA_BLOCK_W  = 512;
    localparam int unsigned SHA_DIGEST_W = 256;
    localparam int unsigned MSG_LEN_BITS = 96;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ISSUE,
        ST_WAIT,
        ST_CHECK,
        ST_FINISH
    } nonce_search_state_t;

    // Single-block padding of a 96-bit message: header, nonce, '1' marker, zeros, bit length.
    function automatic logic [SHA_BLOCK_W-1:0] pad_96(input logic [63:0] header,
                                                      input logic [31:0] nonce);
        return {header, nonce, 1'b1, 351'd0, 64'(MSG_LEN_BITS)};
    endfunction

endpackage

// File: rtl/sha256_nonce_search_if.sv
// Start/done handshake and data buses between the nonce search stage and the SHA-256 core.
interface sha256_nonce_search_if;
    import sha256_pkg::*;

    logic [SHA_BLOCK_W-1:0]  sha_block;
    logic                    sha_start;
    logic                    sha_done;
    logic [SHA_DIGEST_W-1:0] sha_digest;

    modport master (output sha_block, output sha_start, input sha_done, input sha_digest);
    modport slave  (input sha_block, input sha_start, output sha_done, output sha_digest);

endinterface

// File: rtl/sha256_block_pad.sv
// Combinational packing of header and nonce into one padded 512-bit SHA-256 block.
module sha256_block_pad
    import sha256_pkg::*;
(
    input  logic [63:0]            header,
    input  logic [31:0]            nonce,
    output logic [SHA_BLOCK_W-1:0] block
);

    always_comb begin
        block = pad_96(header, nonce);
    end

endmodule

// File: rtl/sha256_nonce_search.sv
// Nonce sweep controller driving a SHA-256 core; optional watchdog via NONCE_SEARCH_TIMEOUT_EN.
module sha256_nonce_search
    import sha256_pkg::*;
#(
    parameter int unsigned NONCE_W        = 32,
    parameter int unsigned TIMEOUT_CYCLES = 128
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    search_start,
    input  logic                    abort,
    input  logic [63:0]             header,
    input  logic [SHA_DIGEST_W-1:0] target,
    input  logic [NONCE_W-1:0]      nonce_first,
    input  logic [NONCE_W-1:0]      nonce_last,
    sha256_nonce_search_if.master   core,
    output logic                    busy,
    output logic                    result_valid,
    output logic                    found,
    output logic [NONCE_W-1:0]      nonce_out,
    output logic [SHA_DIGEST_W-1:0] hash_out,
    output logic [NONCE_W:0]        attempts
`ifdef NONCE_SEARCH_TIMEOUT_EN
    ,
    output logic                    timeout_err
`endif
);

    nonce_search_state_t     state;
    logic [63:0]             hdr_q;
    logic [SHA_DIGEST_W-1:0] tgt_q;
    logic [SHA_DIGEST_W-1:0] dig_q;
    logic [NONCE_W-1:0]      nonce_q;
    logic [NONCE_W-1:0]      last_q;
    logic [NONCE_W-1:0]      pad_nonce;
    logic [SHA_BLOCK_W-1:0]  pad_block;

`ifdef NONCE_SEARCH_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_cnt;
`endif

    // The block register is reloaded in LOAD (first nonce) and CHECK (next nonce).
    always_comb begin
        pad_nonce = (state == ST_CHECK) ? nonce_q + NONCE_W'(1) : nonce_q;
    end

    sha256_block_pad u_pad (
        .header (hdr_q),
        .nonce  (pad_nonce),
        .block  (pad_block)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state          <= ST_IDLE;
            hdr_q          <= '0;
            tgt_q          <= '0;
            dig_q          <= '0;
            nonce_q        <= '0;
            last_q         <= '0;
            core.sha_block <= '0;
            core.sha_start <= 1'b0;
            busy           <= 1'b0;
            result_valid   <= 1'b0;
            found          <= 1'b0;
            nonce_out      <= '0;
            hash_out       <= '0;
            attempts       <= '0;
`ifdef NONCE_SEARCH_TIMEOUT_EN
            wd_cnt         <= '0;
            timeout_err    <= 1'b0;
`endif
        end else if (abort && state != ST_IDLE) begin
            state          <= ST_IDLE;
            core.sha_start <= 1'b0;
            busy           <= 1'b0;
            result_valid   <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    result_valid <= 1'b0;
                    if (search_start) begin
                        hdr_q    <= header;
                        tgt_q    <= target;
                        nonce_q  <= nonce_first;
                        last_q   <= nonce_last;
                        found    <= 1'b0;
                        attempts <= '0;
                        busy     <= 1'b1;
`ifdef NONCE_SEARCH_TIMEOUT_EN
                        timeout_err <= 1'b0;
`endif
                        state    <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    core.sha_block <= pad_block;
                    core.sha_start <= 1'b1;
                    state          <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    core.sha_start <= 1'b0;
`ifdef NONCE_SEARCH_TIMEOUT_EN
                    wd_cnt         <= '0;
`endif
                    state          <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (core.sha_done) begin
                        dig_q <= core.sha_digest;
                        state <= ST_CHECK;
                    end
`ifdef NONCE_SEARCH_TIMEOUT_EN
                    else if (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1)) begin
                        timeout_err  <= 1'b1;
                        found        <= 1'b0;
                        result_valid <= 1'b1;
                        busy         <= 1'b0;
                        state        <= ST_FINISH;
                    end else begin
                        wd_cnt <= wd_cnt + WD_W'(1);
                    end
`endif
                end
                ST_CHECK: begin
                    attempts  <= attempts + (NONCE_W+1)'(1);
                    nonce_out <= nonce_q;
                    hash_out  <= dig_q;
                    if (dig_q < tgt_q || nonce_q == last_q) begin
                        found        <= (dig_q < tgt_q);
                        result_valid <= 1'b1;
                        busy         <= 1'b0;
                        state        <= ST_FINISH;
                    end else begin
                        nonce_q        <= pad_nonce;
                        core.sha_block <= pad_block;
                        core.sha_start <= 1'b1;
                        state          <= ST_ISSUE;
                    end
                end
                ST_FINISH: begin
                    result_valid <= 1'b0;
                    state        <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
